axis_processor_core: RTL and testbench



---
 rtl/axis_processor_core_pkg.sv | 33 +++
 rtl/axis_processor_core_neuron.sv | 80 ++++++++
 rtl/axis_processor_core.sv | 125 ++++++++++++
 tb/tb_axis_processor_core.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_processor_core_pkg.sv
// -----------------------------------------------------------------------------
// processor_config
//   Shared definitions for the AXI4-Stream spiking-network processor:
//   command opcodes, command field bit positions, packet/field widths and
//   the control FSM state type.
// -----------------------------------------------------------------------------
package processor_config;

   localparam int PKT_W      = 8;   // stream byte width (both directions)
   localparam int RUN_CNT_W  = 6;   // RUN timestep count width
   localparam int CHARGE_W   = 2;   // AS charge field width

   // Command field positions
   localparam int OP_MSB     = 7;
   localparam int OP_LSB     = 6;
   localparam int AS_IDX_BIT = 5;
   localparam int AS_CHG_MSB = 4;
   localparam int AS_CHG_LSB = 3;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_RUN = 2'b01,
      OP_AS  = 2'b10,
      OP_CLR = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_STEP = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/axis_processor_core_neuron.sv
// -----------------------------------------------------------------------------
// proc_neuron
//   One integrate-and-fire neuron: a saturating pending-charge accumulator fed
//   by AS commands and a saturating potential that integrates the pending
//   charge on the first timestep of a RUN.
//   Build option PROC_LEAK_EN: when defined, a non-fired potential is cleared
//   at the end of every step (full leak); otherwise it persists.
// Ports
//   clk         in   clock, rising edge
//   arstn       in   asynchronous active-low reset
//   clr         in   zero pending charge and potential
//   add_en      in   add charge to pending (AS addressed to this neuron)
//   charge      in   AS charge value
//   step        in   a timestep executes this cycle
//   first_step  in   this step is the first of the RUN (integrate pending)
//   fire        out  neuron fires on this step (valid while step is high)
// -----------------------------------------------------------------------------
module proc_neuron
   import processor_config::*;
#(
   parameter int POT_W     = 8,
   parameter int THRESHOLD = 1
) (
   input  logic                clk,
   input  logic                arstn,
   input  logic                clr,
   input  logic                add_en,
   input  logic [CHARGE_W-1:0] charge,
   input  logic                step,
   input  logic                first_step,
   output logic                fire
);

   localparam logic [POT_W-1:0] POT_MAX = '1;
   // Threshold compared one bit wider so values above POT_MAX simply never fire
   localparam logic [POT_W:0]   THR     = (POT_W+1)'(THRESHOLD);

   logic [POT_W-1:0] pending_reg;
   logic [POT_W-1:0] potential_reg;

   logic [POT_W:0]   pend_wide;
   logic [POT_W-1:0] pend_next;
   logic [POT_W:0]   pot_wide;
   logic [POT_W-1:0] integrated;

   always_comb begin
      pend_wide  = {1'b0, pending_reg} + {{(POT_W+1-CHARGE_W){1'b0}}, charge};
      pend_next  = pend_wide[POT_W] ? POT_MAX : pend_wide[POT_W-1:0];
      // Pending charge only enters the potential on the RUN's first step
      pot_wide   = {1'b0, potential_reg} + (first_step ? {1'b0, pending_reg} : '0);
      integrated = pot_wide[POT_W] ? POT_MAX : pot_wide[POT_W-1:0];
      fire       = ({1'b0, integrated} >= THR);
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         pending_reg   <= '0;
         potential_reg <= '0;
      end else if (clr) begin
         pending_reg   <= '0;
         potential_reg <= '0;
      end else if (step) begin
         if (first_step) begin
            pending_reg <= '0;
         end
         if (fire) begin
            potential_reg <= '0;
         end else begin
`ifdef PROC_LEAK_EN
            potential_reg <= '0;
`else
            potential_reg <= integrated;
`endif
         end
      end else if (add_en) begin
         pending_reg <= pend_next;
      end
   end

endmodule

// File: rtl/axis_processor_core.sv
// -----------------------------------------------------------------------------
// axis_processor_core
//   Byte-stream spiking-network processor. Commands arrive on an AXI4-Stream
//   slave port (NOP / RUN / AS / CLR); each RUN of N timesteps emits N fire
//   vectors on the AXI4-Stream master port, one byte per timestep.
//   Build option PROC_LEAK_EN (see proc_neuron): full leak of non-fired
//   potentials at the end of every step.
// Ports
//   clk            in   clock, rising edge
//   arstn          in   asynchronous active-low reset
//   s_axis_tdata   in   command byte
//   s_axis_tvalid  in   command valid
//   s_axis_tready  out  command accepted (registered, high only in IDLE)
//   m_axis_tdata   out  fire vector, bit i = neuron i fired, upper bits 0
//   m_axis_tvalid  out  fire vector valid
//   m_axis_tready  in   sink ready
// -----------------------------------------------------------------------------
module axis_processor_core
   import processor_config::*;
#(
   parameter int NUM_INP   = 2,
   parameter int POT_W     = 8,
   parameter int THRESHOLD = 1
) (
   input  logic             clk,
   input  logic             arstn,
   input  logic [PKT_W-1:0] s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [PKT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready
);

   state_t               state_reg;
   logic [RUN_CNT_W-1:0] run_cnt_reg;
   logic                 first_step_reg;
   logic                 s_tready_reg;
   logic                 m_tvalid_reg;
   logic [PKT_W-1:0]     m_tdata_reg;

   logic                 accept;
   opcode_t              opcode;
   logic [RUN_CNT_W-1:0] run_field;
   logic                 clr_pulse;
   logic                 as_pulse;
   logic                 step_pulse;
   logic [NUM_INP-1:0]   fire_vec;

   // s_tready_reg is only ever high in IDLE, so a handshake implies IDLE
   assign accept     = s_axis_tvalid && s_tready_reg;
   assign opcode     = opcode_t'(s_axis_tdata[OP_MSB:OP_LSB]);
   assign run_field  = s_axis_tdata[RUN_CNT_W-1:0];
   assign clr_pulse  = accept && (opcode == OP_CLR);
   assign as_pulse   = accept && (opcode == OP_AS);
   assign step_pulse = (state_reg == ST_STEP);

   generate
      for (genvar gi = 0; gi < NUM_INP; gi++) begin : g_neuron
         localparam logic IDX = 1'(gi);
         proc_neuron #(
            .POT_W      (POT_W),
            .THRESHOLD  (THRESHOLD)
         ) u_neuron (
            .clk        (clk),
            .arstn      (arstn),
            .clr        (clr_pulse),
            .add_en     (as_pulse && (s_axis_tdata[AS_IDX_BIT] == IDX)),
            .charge     (s_axis_tdata[AS_CHG_MSB:AS_CHG_LSB]),
            .step       (step_pulse),
            .first_step (first_step_reg),
            .fire       (fire_vec[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         state_reg      <= ST_IDLE;
         run_cnt_reg    <= '0;
         first_step_reg <= 1'b0;
         s_tready_reg   <= 1'b0;
         m_tvalid_reg   <= 1'b0;
         m_tdata_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               s_tready_reg <= 1'b1;
               // RUN with N=0 is consumed without producing output
               if (accept && (opcode == OP_RUN) && (run_field != '0)) begin
                  run_cnt_reg    <= run_field;
                  first_step_reg <= 1'b1;
                  s_tready_reg   <= 1'b0;
                  state_reg      <= ST_STEP;
               end
            end
            ST_STEP: begin
               m_tdata_reg                <= '0;
               m_tdata_reg[NUM_INP-1:0]   <= fire_vec;
               m_tvalid_reg               <= 1'b1;
               first_step_reg             <= 1'b0;
               state_reg                  <= ST_EMIT;
            end
            ST_EMIT: begin
               if (m_axis_tready) begin
                  m_tvalid_reg <= 1'b0;
                  if (run_cnt_reg > RUN_CNT_W'(1)) begin
                     run_cnt_reg <= run_cnt_reg - RUN_CNT_W'(1);
                     state_reg   <= ST_STEP;
                  end else begin
                     s_tready_reg <= 1'b1;
                     state_reg    <= ST_IDLE;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign s_axis_tready = s_tready_reg;
   assign m_axis_tvalid = m_tvalid_reg;
   assign m_axis_tdata  = m_tdata_reg;

endmodule

// File: tb/tb_axis_processor_core.sv
// -----------------------------------------------------------------------------
// tb_axis_processor_core
//   Drives two processor instances (THRESHOLD=1 and THRESHOLD=4) with the same
//   command stream and compares each emitted fire vector against a timestep-
//   level reference model. Build option PROC_LEAK_EN selects the leaky model.
// -----------------------------------------------------------------------------
module tb_axis_processor_core;

   logic       clk = 1'b0;
   logic       arstn;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       m_tready;

   logic       s_tready_a, s_tready_b;
   logic [7:0] m_tdata_a, m_tdata_b;
   logic       m_tvalid_a, m_tvalid_b;

   always #5 clk = ~clk;

   axis_processor_core #(.NUM_INP(2), .POT_W(8), .THRESHOLD(1)) dut (
      .clk           (clk),
      .arstn         (arstn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready_a),
      .m_axis_tdata  (m_tdata_a),
      .m_axis_tvalid (m_tvalid_a),
      .m_axis_tready (m_tready)
   );

   axis_processor_core #(.NUM_INP(2), .POT_W(8), .THRESHOLD(4)) dut_t4 (
      .clk           (clk),
      .arstn         (arstn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready_b),
      .m_axis_tdata  (m_tdata_b),
      .m_axis_tvalid (m_tvalid_b),
      .m_axis_tready (m_tready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // index [m][i]: m = instance (0: threshold 1, 1: threshold 4), i = neuron
   int unsigned pot  [2][2];
   int unsigned pend [2][2];
   int unsigned th   [2] = '{1, 4};
   logic [7:0]  exp_a[$];
   logic [7:0]  exp_b[$];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 2; i++) begin
            pot[m][i]  = 0;
            pend[m][i] = 0;
         end
      exp_a.delete();
      exp_b.delete();
   endfunction

   function automatic void model_pkt(input logic [7:0] b);
      int unsigned k, n;
      logic [7:0] fv;
      case (b[7:6])
         2'b11: for (int m = 0; m < 2; m++)
                   for (int i = 0; i < 2; i++) begin
                      pot[m][i]  = 0;
                      pend[m][i] = 0;
                   end
         2'b10: begin
            k = b[5];
            for (int m = 0; m < 2; m++) begin
               pend[m][k] = pend[m][k] + b[4:3];
               if (pend[m][k] > 255) pend[m][k] = 255;
            end
         end
         2'b01: begin
            n = b[5:0];
            for (int t = 0; t < int'(n); t++)
               for (int m = 0; m < 2; m++) begin
                  fv = 8'h00;
                  for (int i = 0; i < 2; i++) begin
                     if (t == 0) begin
                        pot[m][i] = pot[m][i] + pend[m][i];
                        if (pot[m][i] > 255) pot[m][i] = 255;
                        pend[m][i] = 0;
                     end
                     if (pot[m][i] >= th[m]) begin
                        fv[i] = 1'b1;
                        pot[m][i] = 0;
                     end else begin
`ifdef PROC_LEAK_EN
                        pot[m][i] = 0;
`endif
                     end
                  end
                  if (m == 0) exp_a.push_back(fv);
                  else        exp_b.push_back(fv);
               end
         end
         default: ;
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic send(input logic [7:0] b);
      int w = 0;
      s_tdata  = b;
      s_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         if (s_tready_a) break;
         w++;
         if (w > 50) begin
            check("send_timeout", 32'(s_tready_a), 32'd1);
            s_tvalid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      model_pkt(b);
      #1;
      s_tvalid = 1'b0;
      $display("cmd 0x%02h accepted at %0t", b, $time);
   endtask

   // Consume every expected packet; hold m_tready low hmin..hmax cycles first
   task automatic collect(input int hmin, input int hmax, input bit chk_lat);
      logic [7:0] ea, eb;
      int w, hold;
      bit first = 1'b1;
      while (exp_a.size() > 0) begin
         ea = exp_a.pop_front();
         eb = exp_b.pop_front();
         w = 0;
         do begin
            @(negedge clk);
            w++;
         end while (!m_tvalid_a && w < 20);
         if (first && chk_lat) check("latency", 32'(w), 32'd2);
         first = 1'b0;
         check("tvalid", 32'(m_tvalid_a), 32'd1);
         if (!m_tvalid_a) begin
            exp_a.delete();
            exp_b.delete();
            return;
         end
         check("tdata_t1", 32'(m_tdata_a), 32'(ea));
         check("tdata_t4", 32'(m_tdata_b), 32'(eb));
         check("tvalid_t4", 32'(m_tvalid_b), 32'd1);
         check("busy_tready", 32'(s_tready_a), 32'd0);
         hold = $urandom_range(hmin, hmax);
         repeat (hold) begin
            @(negedge clk);
            check("hold_tvalid", 32'(m_tvalid_a), 32'd1);
            check("hold_tdata", 32'(m_tdata_a), 32'(ea));
            check("hold_tready", 32'(s_tready_a), 32'd0);
         end
         m_tready = 1'b1;
         @(posedge clk);
         #1;
         m_tready = 1'b0;
         $display("out t1=0x%02h t4=0x%02h at %0t", m_tdata_a, m_tdata_b, $time);
      end
   endtask

   task automatic expect_idle(input string tag);
      repeat (3) @(negedge clk);
      check({tag, "_tvalid"}, 32'(m_tvalid_a), 32'd0);
      check({tag, "_tready"}, 32'(s_tready_a), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] b;
      int r, n;
      arstn    = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = 8'h00;
      m_tready = 1'b0;
      model_reset();

      // Reset pulse of random length
      #3 arstn = 1'b0;
      #($urandom_range(70, 250));
      check("rst_tvalid", 32'(m_tvalid_a), 32'd0);
      check("rst_tready", 32'(s_tready_a), 32'd0);
      check("rst_tdata",  32'(m_tdata_a),  32'd0);
      @(negedge clk);
      arstn = 1'b1;
      #1 check("rel_tready_low", 32'(s_tready_a), 32'd0);
      @(negedge clk);
      check("rel_tready_high", 32'(s_tready_a), 32'd1);
      check("rel_tvalid", 32'(m_tvalid_a), 32'd0);

      // Directed: single-neuron charges, both neurons, threshold 4
      send(8'hC0); send(8'h88); send(8'h43); collect(0, 0, 1'b1);
      send(8'hA8); send(8'h43); collect(0, 0, 1'b1);
      send(8'h88); send(8'hA8); send(8'h43); collect(0, 0, 1'b1);
      send(8'hC0); send(8'h90); send(8'h90); send(8'h41); collect(0, 0, 1'b1);
      send(8'h90); send(8'h42); collect(0, 1, 1'b1);
      send(8'h90); send(8'h41); collect(0, 1, 1'b1);

      // Backpressure held 10 cycles, then RUN 0 produces nothing
      send(8'h88); send(8'h41); collect(10, 10, 1'b1);
      send(8'h40); expect_idle("run0");

      // Reset mid-RUN aborts output; pending charge also cleared
      send(8'h98); send(8'h43);
      @(negedge clk); @(negedge clk);
      check("pre_abort_tvalid", 32'(m_tvalid_a), 32'd1);
      send_abort: begin
         #2 arstn = 1'b0;
         #1;
         check("abort_tvalid", 32'(m_tvalid_a), 32'd0);
         check("abort_tdata",  32'(m_tdata_a),  32'd0);
         check("abort_tready", 32'(s_tready_a), 32'd0);
         model_reset();
         @(negedge clk);
         arstn = 1'b1;
         @(negedge clk);
      end
      send(8'h98);
      arstn = 1'b0;
      #2 arstn = 1'b1;
      model_reset();
      @(negedge clk);
      send(8'h41); collect(0, 0, 1'b1);

      // Randomized command stream
      for (int it = 0; it < 60; it++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      b = {2'b10, 6'($urandom)};
         else if (r < 5) b = {2'b11, 6'($urandom)};
         else if (r < 6) b = {2'b00, 6'($urandom)};
         else begin
            n = $urandom_range(0, 4);
            b = {2'b01, 6'(n)};
         end
         send(b);
         if (b[7:6] == 2'b01) begin
            if (b[5:0] == 6'd0) expect_idle("rand_run0");
            else                collect(0, 3, 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
